// File: rtl/pipe_regs_fde_if.sv
// Bundle between hazard control, fetch/decode logic and the
// F/D/E pipeline register bank.
interface pipe_regs_fde_if #(
   parameter int W     = 64,
   parameter int CNT_W = 32
);
   logic         F_stall;
   logic         D_stall;
   logic         D_bubble;
   logic         E_bubble;

   logic [W-1:0] f_predPC;
   logic [3:0]   f_stat;
   logic [3:0]   f_icode;
   logic [3:0]   f_ifun;
   logic [3:0]   f_rA;
   logic [3:0]   f_rB;
   logic [W-1:0] f_valC;
   logic [W-1:0] f_valP;

   logic [3:0]   d_stat;
   logic [3:0]   d_icode;
   logic [3:0]   d_ifun;
   logic [W-1:0] d_valC;
   logic [W-1:0] d_valA;
   logic [W-1:0] d_valB;
   logic [3:0]   d_dstE;
   logic [3:0]   d_dstM;
   logic [3:0]   d_srcA;
   logic [3:0]   d_srcB;

   logic [W-1:0] F_predPC;
   logic [3:0]   D_stat;
   logic [3:0]   D_icode;
   logic [3:0]   D_ifun;
   logic [3:0]   D_rA;
   logic [3:0]   D_rB;
   logic [W-1:0] D_valC;
   logic [W-1:0] D_valP;
   logic [3:0]   E_stat;
   logic [3:0]   E_icode;
   logic [3:0]   E_ifun;
   logic [3:0]   E_dstE;
   logic [3:0]   E_dstM;
   logic [3:0]   E_srcA;
   logic [3:0]   E_srcB;
   logic [W-1:0] E_valC;
   logic [W-1:0] E_valA;
   logic [W-1:0] E_valB;

   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] bubble_cycles;
   logic             ctl_err;

   modport master (
      output F_stall, D_stall, D_bubble, E_bubble,
      output f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB,
      output f_valC, f_valP,
      output d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
      output d_dstE, d_dstM, d_srcA, d_srcB,
      input  F_predPC,
      input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
      input  E_stat, E_icode, E_ifun, E_dstE, E_dstM,
      input  E_srcA, E_srcB, E_valC, E_valA, E_valB,
      input  stall_cycles, bubble_cycles, ctl_err
   );

   modport slave (
      input  F_stall, D_stall, D_bubble, E_bubble,
      input  f_predPC, f_stat, f_icode, f_ifun, f_rA, f_rB,
      input  f_valC, f_valP,
      input  d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
      input  d_dstE, d_dstM, d_srcA, d_srcB,
      output F_predPC,
      output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
      output E_stat, E_icode, E_ifun, E_dstE, E_dstM,
      output E_srcA, E_srcB, E_valC, E_valA, E_valB,
      output stall_cycles, bubble_cycles, ctl_err
   );
endinterface

// File: rtl/pipe_regs_fde.sv
// Y86-64 F/D/E pipeline registers with hold/bubble control,
// saturating stall/bubble counters and a sticky conflict flag.
module pipe_regs_fde #(
   parameter int W     = 64,
   parameter int CNT_W = 32
) (
   input logic           clk,
   input logic           rst_n,
   pipe_regs_fde_if.slave bus
);
   typedef struct packed {
      logic [3:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [3:0]   ra;
      logic [3:0]   rb;
      logic [W-1:0] valc;
      logic [W-1:0] valp;
   } d_reg_t;

   typedef struct packed {
      logic [3:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [3:0]   dste;
      logic [3:0]   dstm;
      logic [3:0]   srca;
      logic [3:0]   srcb;
      logic [W-1:0] valc;
      logic [W-1:0] vala;
      logic [W-1:0] valb;
   } e_reg_t;

   localparam d_reg_t D_BUB = {
      4'b1000, 4'h1, 4'h0, 4'hF, 4'hF,
      {W{1'b0}}, {W{1'b0}}
   };
   localparam e_reg_t E_BUB = {
      4'b1000, 4'h1, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF,
      {W{1'b0}}, {W{1'b0}}, {W{1'b0}}
   };

   logic [W-1:0]     pc_d, pc_q;
   d_reg_t           dr_d, dr_q;
   e_reg_t           er_d, er_q;
   logic [CNT_W-1:0] stall_d, stall_q;
   logic [CNT_W-1:0] bub_d, bub_q;
   logic             err_d, err_q;
   logic             conflict;

   // Stall beats bubble on D; a conflicting cycle still behaves this way.
   assign conflict = bus.D_stall & (bus.D_bubble | ~bus.F_stall);

   always_comb begin
      pc_d = bus.F_stall ? pc_q : bus.f_predPC;

      dr_d = dr_q;
      if (!bus.D_stall) begin
         if (bus.D_bubble) begin
            dr_d = D_BUB;
         end else begin
            dr_d = {bus.f_stat, bus.f_icode, bus.f_ifun,
                    bus.f_rA, bus.f_rB,
                    bus.f_valC, bus.f_valP};
         end
      end

      er_d = E_BUB;
      if (!bus.E_bubble) begin
         er_d = {bus.d_stat, bus.d_icode, bus.d_ifun,
                 bus.d_dstE, bus.d_dstM,
                 bus.d_srcA, bus.d_srcB,
                 bus.d_valC, bus.d_valA, bus.d_valB};
      end

      stall_d = stall_q;
      if ((bus.F_stall | bus.D_stall) && (stall_q != '1)) begin
         stall_d = stall_q + CNT_W'(1);
      end

      bub_d = bub_q;
      if ((bus.D_bubble | bus.E_bubble) && (bub_q != '1)) begin
         bub_d = bub_q + CNT_W'(1);
      end

      err_d = err_q | conflict;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= '0;
         dr_q    <= D_BUB;
         er_q    <= E_BUB;
         stall_q <= '0;
         bub_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         dr_q    <= dr_d;
         er_q    <= er_d;
         stall_q <= stall_d;
         bub_q   <= bub_d;
         err_q   <= err_d;
      end
   end

   assign bus.F_predPC      = pc_q;
   assign bus.D_stat        = dr_q.stat;
   assign bus.D_icode       = dr_q.icode;
   assign bus.D_ifun        = dr_q.ifun;
   assign bus.D_rA          = dr_q.ra;
   assign bus.D_rB          = dr_q.rb;
   assign bus.D_valC        = dr_q.valc;
   assign bus.D_valP        = dr_q.valp;
   assign bus.E_stat        = er_q.stat;
   assign bus.E_icode       = er_q.icode;
   assign bus.E_ifun        = er_q.ifun;
   assign bus.E_dstE        = er_q.dste;
   assign bus.E_dstM        = er_q.dstm;
   assign bus.E_srcA        = er_q.srca;
   assign bus.E_srcB        = er_q.srcb;
   assign bus.E_valC        = er_q.valc;
   assign bus.E_valA        = er_q.vala;
   assign bus.E_valB        = er_q.valb;
   assign bus.stall_cycles  = stall_q;
   assign bus.bubble_cycles = bub_q;
   assign bus.ctl_err       = err_q;
endmodule
